bus_readback: RTL
=================

Name: bus_readback

Overview:
- CPU read-path for the GPU register window; the counterpart of the write-side bus interface.
- Serves CPU reads of the 8-entry register window (addr 0-7).
- Prefetches bytes from tile, attribute and colour memory through a data port (addr 6) with an auto-advancing 16-bit read pointer.
- Sits between the synchronised CPU bus front-end and the read ports of the GPU memories. The renderer owns those read ports, so this block only reads when granted.

Parameters:
- TILE_END, 16'h0800, first address past tile memory
- ATTR_END, 16'h1800, first address past attribute memory; colour space starts here
- PTR_W, 16, read pointer width

Ports:
- clk  in  1  GPU system clock
- rst_n  in  1  asynchronous active-low reset
- bus_cs  in  1  CPU access strobe, already synchronised to clk, level-high for the whole access
- bus_rw  in  1  1 = read, 0 = write; valid while bus_cs high
- bus_addr  in  3  register index; valid while bus_cs high
- data_out  out  8  read data toward the CPU data bus driver
- data_oe  out  1  drive enable for data_out
- ptr_load  in  1  one-cycle pulse from the write side when the CPU writes pointer reg 4 or 5
- ptr_load_value  in  16  new pointer value {reg5, reg4}; valid with ptr_load
- incr_value  in  8  current auto-increment register (reg 3)
- mem_rd_grant  in  1  renderer leaves the memory read ports free this cycle
- tile_rd_addr  out  11  tile memory read address
- attr_rd_addr  out  12  attribute memory read address
- color_rd_addr  out  4  colour memory read address
- mem_rd_en  out  1  read strobe, shared by all three memories
- tile_rd_data  in  8  tile memory data, 1-cycle latency
- attr_rd_data  in  8  attribute memory data, 1-cycle latency
- color_rd_data  in  8  colour memory data, 1-cycle latency

Behaviour:
- Reset (async, rst_n low): data_out=0, data_oe=0, mem_rd_en=0, all rd_addr=0, ptr=0, buffer=0, buf_valid=0, FSM=IDLE. After release, the FSM enters ISSUE on the next clk.
- Access detect: bus_cs rising edge (registered compare) with bus_rw=1.
  - data_out is loaded on that clk edge.
  - data_oe goes 1 on the same edge and stays 1 until the clk after bus_cs falls. Latency is 1 clk.
- Read mux, by bus_addr at the rising edge:
  - 3 = incr_value
  - 4 = ptr[7:0]
  - 5 = ptr[15:8]
  - 6 = buffer
  - 7 = status {7'b0, buf_valid}
  - 0-2 = 8'h00
- Data-port advance: on bus_cs falling edge, if the access was a read of addr 6:
  - ptr <= ptr + zero-extended incr_value, mod 2^16; wrap from FFFF to 0000 is legal.
  - buf_valid <= 0.
  - FSM goes to ISSUE.
  - incr_value = 0 still refetches the same address.
- A read of addr 6 while buf_valid=0 returns the stale buffer. It still advances the pointer. The CPU is expected to poll addr 7.
- Writes (bus_rw=0) never drive data_oe and never advance the pointer.
- Prefetch FSM:
  - IDLE: buffer holds valid data; waits for an advance or a load.
  - ISSUE: mem_rd_en and addresses are asserted only in a cycle where mem_rd_grant=1, then go to WAIT. Otherwise stay in ISSUE with mem_rd_en=0.
  - WAIT: capture the selected memory's data into the buffer, set buf_valid=1, go to IDLE.
- Address decode of ptr:
  - ptr < TILE_END: tile, address ptr[10:0]
  - TILE_END <= ptr < ATTR_END: attribute, address (ptr - TILE_END)[11:0]
  - ptr >= ATTR_END: colour, address ptr[3:0]
- The selected region is registered at ISSUE and used to mux the data in WAIT.
- ptr_load: ptr <= ptr_load_value, buf_valid <= 0, FSM goes to ISSUE.
  - A load arriving in WAIT discards that cycle's capture.
  - A load arriving in the same cycle as an advance wins; incr is not applied.
- Grant must be re-sampled each cycle. mem_rd_en is never high without mem_rd_grant.

Decomposition:
- Shared gpu package holds:
  - register indices REG_INCR=3, REG_PTR_LO=4, REG_PTR_HI=5, REG_DATA=6, REG_STATUS=7
  - TILE_END and ATTR_END
  - a region enum {REGION_TILE, REGION_ATTR, REGION_COLOR}
- The write-side interface uses the same package.
- One natural sub-module: gpu_addr_decode, a combinational function of ptr that returns region and local address. It is shared with the write side.

Test Plan:
- Reset: hold rst_n low mid-WAIT, then release. Required: data_oe=0, ptr=0, and buf_valid=1 within 3 clk (grant tied 1), with buffer = tile[0].
- Load then read: load 16'h0005 with incr 1, tile[5]=8'hA5, tile[6]=8'h3C. Required:
  - addr 7 reads 8'h01
  - addr 6 reads A5
  - after cs falls, ptr=0006 and addr 6 reads 3C
- Region boundaries: load 07FF, then 0800, then 1800, then 1803. Required data: tile[7FF], attr[000], color[0], color[3].
- Wrap-around: load FFFE with incr 3, then read addr 6. Required: ptr=0001 (addr 4 = 01, addr 5 = 00), and the buffer refetches tile[1].
- Grant starvation: hold mem_rd_grant=0 for 10 clk after a load. Required:
  - mem_rd_en stays 0 throughout
  - status = 00
  - buffer valid 2 clk after grant returns
- Load collides with advance in the same clk: ptr equals the load value, not load+incr, and any WAIT capture already in flight is discarded.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: register indices, memory-map boundaries and the
// region/state encodings used by both the read and write bus interfaces.
package gpu_pkg;

  localparam int PTR_W = 16;

  localparam logic [2:0] REG_INCR   = 3'd3;
  localparam logic [2:0] REG_PTR_LO = 3'd4;
  localparam logic [2:0] REG_PTR_HI = 3'd5;
  localparam logic [2:0] REG_DATA   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam logic [PTR_W-1:0] TILE_END = 16'h0800;
  localparam logic [PTR_W-1:0] ATTR_END = 16'h1800;

  typedef enum logic [1:0] {
    REGION_TILE,
    REGION_ATTR,
    REGION_COLOR
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } rd_state_e;

endpackage

// File: rtl/gpu_addr_decode.sv
// Splits a 16-bit data-port pointer into the memory region it falls in and
// the local address inside that memory.
module gpu_addr_decode
  import gpu_pkg::*;
(
  input  logic [15:0] ptr,
  output region_e     region,
  output logic [11:0] local_addr
);

  always_comb begin
    region     = REGION_COLOR;
    local_addr = {8'h00, ptr[3:0]};
    if (ptr < TILE_END) begin
      region     = REGION_TILE;
      local_addr = {1'b0, ptr[10:0]};
    end else if (ptr < ATTR_END) begin
      region     = REGION_ATTR;
      // Attribute space spans exactly 4 KiB, so the low 12 bits of the
      // offset are all that matter.
      local_addr = ptr[11:0] - TILE_END[11:0];
    end
  end

endmodule

// File: rtl/bus_readback.sv
// CPU read path of the GPU register window: register read mux plus a
// prefetching data port that borrows the memory read ports when granted.
module bus_readback
  import gpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_cs,
  input  logic        bus_rw,
  input  logic [2:0]  bus_addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        ptr_load,
  input  logic [15:0] ptr_load_value,
  input  logic [7:0]  incr_value,
  input  logic        mem_rd_grant,
  output logic [10:0] tile_rd_addr,
  output logic [11:0] attr_rd_addr,
  output logic [3:0]  color_rd_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  tile_rd_data,
  input  logic [7:0]  attr_rd_data,
  input  logic [7:0]  color_rd_data
);

  rd_state_e        state, state_next;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       buffer;
  logic             buf_valid;
  region_e          region_q;
  logic             cs_q;
  logic             acc_data;

  region_e     cur_region;
  logic [11:0] cur_local;
  logic        cs_rise, cs_fall, advance, restart, issue, capture;
  logic [7:0]  rd_mux, mem_sel;

  gpu_addr_decode u_decode (
    .ptr        (ptr),
    .region     (cur_region),
    .local_addr (cur_local)
  );

  // Memory handshake: a read is issued only in a cycle where state is ISSUE
  // and mem_rd_grant is high; the addressed memory returns data one cycle
  // later, which is captured in WAIT unless a pointer change supersedes it.
  assign cs_rise = bus_cs & ~cs_q;
  assign cs_fall = ~bus_cs & cs_q;
  assign advance = cs_fall & acc_data;
  assign restart = ptr_load | advance;
  assign issue   = (state == ST_ISSUE) & mem_rd_grant;
  assign capture = (state == ST_WAIT) & ~restart;

  assign mem_rd_en     = issue;
  assign tile_rd_addr  = (issue && cur_region == REGION_TILE)  ? cur_local[10:0] : 11'd0;
  assign attr_rd_addr  = (issue && cur_region == REGION_ATTR)  ? cur_local       : 12'd0;
  assign color_rd_addr = (issue && cur_region == REGION_COLOR) ? cur_local[3:0]  : 4'd0;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!buf_valid) state_next = ST_ISSUE;
      ST_ISSUE: if (mem_rd_grant) state_next = ST_WAIT;
      ST_WAIT:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (restart) state_next = ST_ISSUE;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus_addr)
      REG_INCR:   rd_mux = incr_value;
      REG_PTR_LO: rd_mux = ptr[7:0];
      REG_PTR_HI: rd_mux = ptr[15:8];
      REG_DATA:   rd_mux = buffer;
      REG_STATUS: rd_mux = {7'b0, buf_valid};
      default:    rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    mem_sel = color_rd_data;
    case (region_q)
      REGION_TILE: mem_sel = tile_rd_data;
      REGION_ATTR: mem_sel = attr_rd_data;
      default:     mem_sel = color_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      buffer    <= 8'h00;
      buf_valid <= 1'b0;
      region_q  <= REGION_TILE;
    end else begin
      state <= state_next;
      if (issue) region_q <= cur_region;
      // A load takes priority over a data-port advance in the same cycle.
      if (ptr_load)     ptr <= ptr_load_value;
      else if (advance) ptr <= ptr + {8'h00, incr_value};
      if (restart) begin
        buf_valid <= 1'b0;
      end else if (capture) begin
        buf_valid <= 1'b1;
        buffer    <= mem_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 1'b0;
      acc_data <= 1'b0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
    end else begin
      cs_q <= bus_cs;
      if (cs_rise) begin
        acc_data <= bus_rw && (bus_addr == REG_DATA);
        if (bus_rw) begin
          data_out <= rd_mux;
          data_oe  <= 1'b1;
        end
      end else if (cs_fall) begin
        acc_data <= 1'b0;
        data_oe  <= 1'b0;
      end
    end
  end

endmodule
